// File: rtl/diff_demo_pkg.sv
// Shared configuration and state encoding for the feature-map write-back path.
package diff_demo_pkg;

    localparam int CONF_PE_ROW       = 4;
    localparam int CONF_FM_BUF_DEPTH = 4096;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_SETUP,
        WB_RUN,
        WB_DONE
    } wb_state_e;

endpackage

// File: rtl/fm_wb_arbiter_rr.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves just past the winner on advance.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = IDX_W'((int'(ptr_q) + i) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fm_wb_arbiter.sv
// Shares the fm/guard write port among PE-row write-back channels. Each row writes
// one output-channel plane at a channel-major address.
//
// state    | meaning
// WB_IDLE  | waiting for start; the group configuration is captured on start
// WB_SETUP | NUM_REQ cycles; builds one row base per cycle and clears that row's pixel counter
// WB_RUN   | arbitrates the rows and registers one write per handshake
// WB_DONE  | single cycle with wb_done high
module fm_wb_arbiter
    import diff_demo_pkg::*;
#(
    parameter int NUM_REQ = CONF_PE_ROW,
    parameter int ADDR_W  = $clog2(CONF_FM_BUF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       plane_size,
    input  logic [7:0]              co_base,
    input  logic [NUM_REQ-1:0]      row_en,
    output logic                    busy,
    output logic                    wb_done,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0][5:0] req_guard,
    output logic [NUM_REQ-1:0]      row_done,
    output logic                    fm_wr_en,
    output logic                    gd_wr_en,
    output logic [ADDR_W-1:0]       fm_wr_addr,
    output logic [ADDR_W-1:0]       gd_wr_addr,
    output logic [7:0]              fm_din,
    output logic [5:0]              gd_din
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_state_e          state_q;
    logic               busy_q;
    logic               wb_done_q;
    logic [IDX_W-1:0]   setup_idx_q;
    logic [ADDR_W-1:0]  plane_q;
    logic [7:0]         co_base_q;
    logic [NUM_REQ-1:0] row_en_q;
    logic [NUM_REQ-1:0] row_done_q;

    logic [ADDR_W-1:0]  base_q    [NUM_REQ];
    logic [ADDR_W-1:0]  pix_cnt_q [NUM_REQ];
    logic [ADDR_W-1:0]  acc_q;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         fm_din_q;
    logic [5:0]         gd_din_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               handshake;
    logic               all_fin;
    logic [ADDR_W-1:0]  base_d;
    logic [ADDR_W-1:0]  pix_sel;
    logic [ADDR_W-1:0]  wr_addr_d;

    // Finished rows drop out of arbitration, so their extra valids are never written.
    assign eligible  = (state_q == WB_RUN) ? (row_en_q & ~row_done_q & req_valid) : '0;
    assign handshake = |(req_valid & gnt);
    assign all_fin   = &(row_done_q | ~row_en_q);

    // Only the low ADDR_W bits of the product are kept, so the multiply is done at that width.
    assign base_d    = (setup_idx_q == '0) ? (ADDR_W'(co_base_q) * plane_q) : (acc_q + plane_q);
    assign pix_sel   = pix_cnt_q[gnt_idx];
    assign wr_addr_d = base_q[gnt_idx] + pix_sel;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible),
        .advance (handshake),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WB_IDLE;
            busy_q      <= 1'b0;
            wb_done_q   <= 1'b0;
            setup_idx_q <= '0;
            plane_q     <= '0;
            co_base_q   <= '0;
            row_en_q    <= '0;
        end else begin
            wb_done_q <= 1'b0;
            case (state_q)
                WB_IDLE: begin
                    if (start) begin
                        state_q     <= WB_SETUP;
                        busy_q      <= 1'b1;
                        plane_q     <= plane_size;
                        co_base_q   <= co_base;
                        row_en_q    <= row_en;
                        setup_idx_q <= '0;
                    end
                end
                WB_SETUP: begin
                    if (setup_idx_q == IDX_W'(NUM_REQ - 1)) begin
                        state_q <= WB_RUN;
                    end else begin
                        setup_idx_q <= setup_idx_q + IDX_W'(1);
                    end
                end
                WB_RUN: begin
                    if (all_fin) begin
                        state_q   <= WB_DONE;
                        wb_done_q <= 1'b1;
                    end
                end
                WB_DONE: begin
                    state_q <= WB_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= WB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                base_q[r]    <= '0;
                pix_cnt_q[r] <= '0;
            end
            acc_q      <= '0;
            row_done_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            fm_din_q   <= '0;
            gd_din_q   <= '0;
        end else begin
            wr_en_q <= handshake;
            if (handshake) begin
                wr_addr_q          <= wr_addr_d;
                fm_din_q           <= req_data[gnt_idx];
                gd_din_q           <= req_guard[gnt_idx];
                pix_cnt_q[gnt_idx] <= pix_sel + ADDR_W'(1);
                if (pix_sel == plane_q - ADDR_W'(1)) begin
                    row_done_q[gnt_idx] <= 1'b1;
                end
            end
            if (state_q == WB_IDLE && start) begin
                row_done_q <= '0;
            end
            if (state_q == WB_SETUP) begin
                base_q[setup_idx_q]    <= base_d;
                acc_q                  <= base_d;
                pix_cnt_q[setup_idx_q] <= '0;
            end
        end
    end

    assign busy       = busy_q;
    assign wb_done    = wb_done_q;
    assign req_ready  = gnt;
    assign row_done   = row_done_q;
    assign fm_wr_en   = wr_en_q;
    assign gd_wr_en   = wr_en_q;
    assign fm_wr_addr = wr_addr_q;
    assign gd_wr_addr = wr_addr_q;
    assign fm_din     = fm_din_q;
    assign gd_din     = gd_din_q;

endmodule

// File: tb/tb_fm_wb_arbiter.sv
// Bench for fm_wb_arbiter: a cycle-level behavioural model compared on every negedge,
// plus literal expectations for the addressing, fairness, partial-group, wrap and reset cases.
module tb_fm_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     plane_size = '0;
    logic [7:0]        co_base = '0;
    logic [N-1:0]      row_en = '0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0][7:0] req_data = '0;
    logic [N-1:0][5:0] req_guard = '0;
    logic              busy, wb_done, fm_wr_en, gd_wr_en;
    logic [N-1:0]      req_ready, row_done;
    logic [AW-1:0]     fm_wr_addr, gd_wr_addr;
    logic [7:0]        fm_din;
    logic [5:0]        gd_din;

    fm_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .plane_size (plane_size),
        .co_base    (co_base),
        .row_en     (row_en),
        .busy       (busy),
        .wb_done    (wb_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_guard  (req_guard),
        .row_done   (row_done),
        .fm_wr_en   (fm_wr_en),
        .gd_wr_en   (gd_wr_en),
        .fm_wr_addr (fm_wr_addr),
        .gd_wr_addr (gd_wr_addr),
        .fm_din     (fm_din),
        .gd_din     (gd_din)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 setup, 2 run, 3 done.
    int       m_phase, m_left, m_ptr, m_plane, m_co;
    bit [3:0] m_en, m_done;
    int       m_cnt [N];
    bit       m_wr;
    int       m_addr, m_fm, m_gd;

    int       cyc = 0, last_wr_cyc = 0, wbd_cyc = 0;
    int       wr_log [$];
    int       gnt_log [$];

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_ptr = 0; m_plane = 0; m_co = 0;
        m_en = '0; m_done = '0; m_wr = 1'b0; m_addr = 0; m_fm = 0; m_gd = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        int       g;
        int       r;
        bit [3:0] exp_rdy;
        bit       all_fin;
        cyc++;
        if (!rst_n) model_reset();
        g = -1;
        exp_rdy = '0;
        if (m_phase == 2) begin
            for (int i = 0; i < N; i++) begin
                r = (m_ptr + i) % N;
                if (g < 0 && m_en[r] && !m_done[r] && req_valid[r]) g = r;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        check("busy", busy, (m_phase != 0));
        check("wb_done", wb_done, (m_phase == 3));
        check("req_ready", req_ready, exp_rdy);
        check("row_done", row_done, m_done);
        check("fm_wr_en", fm_wr_en, m_wr);
        check("gd_wr_en", gd_wr_en, m_wr);
        if (m_wr) begin
            check("fm_wr_addr", fm_wr_addr, m_addr);
            check("gd_wr_addr", gd_wr_addr, m_addr);
            check("fm_din", fm_din, m_fm);
            check("gd_din", gd_din, m_gd);
        end

        if (fm_wr_en) begin
            wr_log.push_back(int'(fm_wr_addr));
            last_wr_cyc = cyc;
        end
        for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
        if (wb_done) wbd_cyc = cyc;

        if (rst_n) begin
            all_fin = &(m_done | ~m_en);
            m_wr = (g >= 0);
            if (g >= 0) begin
                m_addr = ((m_co + g) * m_plane + m_cnt[g]) % 4096;
                m_fm   = int'(req_data[g]);
                m_gd   = int'(req_guard[g]);
                m_cnt[g]++;
                if (m_cnt[g] == m_plane) m_done[g] = 1'b1;
                m_ptr = (g + 1) % N;
            end
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_left = N;
                    m_plane = int'(plane_size); m_co = int'(co_base); m_en = row_en;
                    m_done = '0;
                    for (int i = 0; i < N; i++) m_cnt[i] = 0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (all_fin) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    // mode 0: all rows valid; 1: rows 1/3, row 2 joins once ptr reaches 2; 2: random valid and stray starts
    task automatic run_group(input int plane, input int co, input bit [3:0] en,
                             input int mode, input int budget);
        bit done_seen;
        wr_log.delete();
        gnt_log.delete();
        @(posedge clk); #1;
        start = 1'b1; plane_size = AW'(plane); co_base = 8'(co); row_en = en;
        @(posedge clk); #1;
        start = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            for (int i = 0; i < N; i++) begin
                req_data[i]  = 8'($urandom);
                req_guard[i] = 6'($urandom);
            end
            case (mode)
                0: req_valid = 4'hF;
                1: begin
                    if (gnt_log.size() >= 6) req_valid = 4'hF;
                    else if (gnt_log.size() >= 5 && m_ptr == 2) req_valid = 4'b1110;
                    else req_valid = 4'b1010;
                end
                default: begin
                    req_valid  = 4'($urandom);
                    start      = ($urandom_range(0, 4) == 0);
                    plane_size = AW'($urandom);
                    co_base    = 8'($urandom);
                    row_en     = 4'($urandom);
                end
            endcase
            @(posedge clk); #1;
            if (wb_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        req_valid = '0;
        start = 1'b0;
        check("group_done_in_budget", done_seen, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic addr_group_checks();
        check("addr_write_count", wr_log.size(), 24);
        if (wr_log.size() >= 24) begin
            check("addr_first_row0", wr_log[0], 24);
            check("addr_first_row1", wr_log[1], 30);
            check("addr_first_row2", wr_log[2], 36);
            check("addr_first_row3", wr_log[3], 42);
            for (int k = 0; k < 6; k++) check("addr_row0_seq", wr_log[4 * k], 24 + k);
        end
        check("addr_wbdone_after_last_write", wbd_cyc - last_wr_cyc, 1);
    endtask

    initial begin
        int bad_rows;
        #50_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt23;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_fm_wr_en", fm_wr_en, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_row_done", row_done, 0);
        check("rst_fm_wr_addr", fm_wr_addr, 0);
        #2 rst_n = 1'b1;

        // Address generation: bases 24/30/36/42, strict 0,1,2,3 rotation.
        run_group(6, 4, 4'hF, 0, 200);
        addr_group_checks();

        // Fairness: expected grant order 1,3,1,3,1,2.
        run_group(8, 10, 4'hF, 1, 400);
        if (gnt_log.size() >= 6) begin
            check("rr_g0", gnt_log[0], 1);
            check("rr_g1", gnt_log[1], 3);
            check("rr_g2", gnt_log[2], 1);
            check("rr_g3", gnt_log[3], 3);
            check("rr_g4", gnt_log[4], 1);
            check("rr_g5", gnt_log[5], 2);
        end else begin
            check("rr_grant_count", gnt_log.size(), 6);
        end

        // Partial group: only rows 0/1, 2 pixels each.
        run_group(2, 7, 4'b0011, 0, 200);
        check("partial_write_count", wr_log.size(), 4);
        check("partial_row_done", row_done, 4'b0011);
        cnt23 = 0;
        foreach (gnt_log[i]) if (gnt_log[i] >= 2) cnt23++;
        check("partial_no_row23_grant", cnt23, 0);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        start = 1'b1; plane_size = 12'd6; co_base = 8'd4; row_en = 4'hF;
        @(posedge clk); #1;
        start = 1'b0; req_valid = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_wr_en", fm_wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_fm_wr_en", fm_wr_en, 0);
        check("midrst_row_done", row_done, 0);
        check("midrst_wb_done", wb_done, 0);
        req_valid = '0;
        @(negedge clk); #1 rst_n = 1'b1;

        // Restarted group behaves as from reset.
        run_group(6, 4, 4'hF, 0, 200);
        addr_group_checks();

        // Wrap-around: base 3841, addresses wrap through 0.
        run_group(4095, 255, 4'b0001, 0, 4300);
        check("wrap_write_count", wr_log.size(), 4095);
        if (wr_log.size() >= 256) begin
            check("wrap_first_addr", wr_log[0], 3841);
            check("wrap_last_before_wrap", wr_log[254], 4095);
            check("wrap_after_wrap", wr_log[255], 0);
        end

        // Random valid patterns, stray starts while busy, changing config inputs.
        for (int t = 0; t < 8; t++) begin
            run_group($urandom_range(1, 12), $urandom_range(0, 255), 4'($urandom), 2, 2000);
        end

        // Degenerate group: no rows enabled.
        run_group(5, 3, 4'b0000, 0, 50);
        check("empty_write_count", wr_log.size(), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
